velocity_estimator: RTL and testbench

- Downstream stage of position_tracker: consumes its signed fringe-position stream and emits one velocity sample per programmable window of 2^L input samples.
- The velocity sample is the position delta over the window.
- Output is an AXI-Stream master with back-pressure and a one-entry output register, feeding the DMA/ram-writer path.
- Input has no back-pressure, because position_tracker cannot stall; the block never drops input samples.

---
 rtl/velocity_estimator_if.sv | 30 +++
 rtl/velocity_estimator.sv | 107 ++++++++++
 tb/tb_velocity_estimator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/velocity_estimator_if.sv
// rtl/velocity_estimator_if.sv - position-in / velocity-out stream bundle for velocity_estimator
interface velocity_estimator_if #(
    parameter int AXIS_TDATA_WIDTH = 32
);
    // Input position stream (no back-pressure)
    logic                        S_AXIS_tvalid;
    logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata;
    // Output velocity stream
    logic                        M_AXIS_tvalid;
    logic                        M_AXIS_tready;
    logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata;

    // Estimator view: sinks positions, sources velocities
    modport master (
        input  S_AXIS_tvalid,
        input  S_AXIS_tdata,
        output M_AXIS_tvalid,
        input  M_AXIS_tready,
        output M_AXIS_tdata
    );

    // Environment view: sources positions, sinks velocities
    modport slave (
        output S_AXIS_tvalid,
        output S_AXIS_tdata,
        input  M_AXIS_tvalid,
        output M_AXIS_tready,
        input  M_AXIS_tdata
    );
endinterface

// File: rtl/velocity_estimator.sv
// rtl/velocity_estimator.sv - windowed position-delta velocity estimator (option: VELOCITY_ESTIMATOR_SCALE_EN)
module velocity_estimator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int LOG_COUNT_WIDTH  = 5,
    parameter int MAX_LOG_COUNT    = 16
) (
    input  logic                       SYS_aclk,
    input  logic                       SYS_aresetn,
    input  logic [LOG_COUNT_WIDTH-1:0] FC_log_count,
    velocity_estimator_if.master       axis,
    output logic                       ST_overrun
);
    localparam int W   = AXIS_TDATA_WIDTH;
    localparam int CW  = MAX_LOG_COUNT;
    localparam int L_W = $clog2(MAX_LOG_COUNT + 1);

    typedef enum logic {
        WAIT_REF,
        ACCUM
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   counter_q;
    logic [W-1:0]    pos_ref_q;
    logic [L_W-1:0]  l_q;
    logic            m_tvalid_q;
    logic [W-1:0]    m_tdata_q;
    logic            overrun_q;

    logic [L_W-1:0]  l_d;
    logic [CW:0]     win_last_w;
    logic            close_w;
    logic [W-1:0]    result_w;
    logic [W-1:0]    out_w;

    // Clamp the requested exponent, work out the window's last count and the delta
    always_comb begin
        l_d = L_W'(FC_log_count);
        if (32'(FC_log_count) > 32'(MAX_LOG_COUNT)) begin
            l_d = L_W'(MAX_LOG_COUNT);
        end
        win_last_w = ((CW + 1)'(1) << l_q) - (CW + 1)'(1);
        close_w    = (state_q == ACCUM) && axis.S_AXIS_tvalid
                     && (counter_q == win_last_w[CW-1:0]);
        // Wrap-around subtraction gives the true delta while it fits in W bits
        result_w   = axis.S_AXIS_tdata - pos_ref_q;
`ifdef VELOCITY_ESTIMATOR_SCALE_EN
        // Mean per-sample velocity using the exponent of the window just closed
        out_w      = $signed(result_w) >>> l_q;
`else
        out_w      = result_w;
`endif
    end

    // Window FSM plus the one-entry output register and sticky overrun flag
    always_ff @(posedge SYS_aclk) begin
        if (!SYS_aresetn) begin
            state_q    <= WAIT_REF;
            counter_q  <= '0;
            pos_ref_q  <= '0;
            l_q        <= '0;
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            case (state_q)
                WAIT_REF: begin
                    if (axis.S_AXIS_tvalid) begin
                        pos_ref_q <= axis.S_AXIS_tdata;
                        counter_q <= '0;
                        l_q       <= l_d;
                        state_q   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (axis.S_AXIS_tvalid) begin
                        if (close_w) begin
                            pos_ref_q <= axis.S_AXIS_tdata;
                            counter_q <= '0;
                            l_q       <= l_d;
                        end else begin
                            counter_q <= counter_q + CW'(1);
                        end
                    end
                end
                default: state_q <= WAIT_REF;
            endcase

            if (m_tvalid_q && axis.M_AXIS_tready) begin
                m_tvalid_q <= 1'b0;
            end
            // A slot is free if empty or being drained this cycle; otherwise drop the result
            if (close_w) begin
                if (!m_tvalid_q || axis.M_AXIS_tready) begin
                    m_tvalid_q <= 1'b1;
                    m_tdata_q  <= out_w;
                end else begin
                    overrun_q  <= 1'b1;
                end
            end
        end
    end

    assign axis.M_AXIS_tvalid = m_tvalid_q;
    assign axis.M_AXIS_tdata  = m_tdata_q;
    assign ST_overrun         = overrun_q;
endmodule

// File: tb/tb_velocity_estimator.sv
// tb/tb_velocity_estimator.sv - directed and randomized bench for velocity_estimator
module tb_velocity_estimator;
    localparam int W   = 32;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] fc = 5'd0;
    logic       ovr;

    int compared   = 0;
    int mismatched = 0;

    velocity_estimator_if #(.AXIS_TDATA_WIDTH(W)) bus ();

    velocity_estimator #(
        .AXIS_TDATA_WIDTH(W),
        .LOG_COUNT_WIDTH(5),
        .MAX_LOG_COUNT(MAXL)
    ) dut (
        .SYS_aclk    (clk),
        .SYS_aresetn (rstn),
        .FC_log_count(fc),
        .axis        (bus),
        .ST_overrun  (ovr)
    );

    always #5 clk = ~clk;

    // Reference model: samples seen since the reference, window size from the latched exponent
    bit          m_have_ref;
    int          m_seen;
    int          m_l;
    logic [W-1:0] m_ref;
    logic        m_valid;
    logic [W-1:0] m_data;
    logic        m_ovr;

    function automatic logic [W-1:0] scale(input logic [W-1:0] delta, input int l);
`ifdef VELOCITY_ESTIMATOR_SCALE_EN
        longint r, p, q;
        r = longint'($signed(delta));
        p = longint'(1) << l;
        if (r >= 0) q = r / p;
        else        q = -((-r + p - 1) / p);
        return q[W-1:0];
`else
        return delta;
`endif
    endfunction

    task automatic model_edge();
        bit closed;
        logic [W-1:0] res;
        int lclose;
        closed = 0;
        if (!rstn) begin
            m_have_ref = 0; m_seen = 0; m_l = 0; m_ref = '0;
            m_valid = 0; m_data = '0; m_ovr = 0;
            return;
        end
        if (bus.S_AXIS_tvalid) begin
            if (!m_have_ref) begin
                m_have_ref = 1;
                m_ref  = bus.S_AXIS_tdata;
                m_seen = 0;
                m_l    = (int'(fc) > MAXL) ? MAXL : int'(fc);
            end else begin
                m_seen++;
                if (m_seen == (1 << m_l)) begin
                    res    = bus.S_AXIS_tdata - m_ref;
                    lclose = m_l;
                    res    = scale(res, lclose);
                    m_ref  = bus.S_AXIS_tdata;
                    m_seen = 0;
                    m_l    = (int'(fc) > MAXL) ? MAXL : int'(fc);
                    closed = 1;
                end
            end
        end
        if (closed) begin
            if (m_valid && !bus.M_AXIS_tready) begin
                m_ovr = 1;
            end else begin
                m_valid = 1;
                m_data  = res;
            end
        end else if (m_valid && bus.M_AXIS_tready) begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h time=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic rdy);
        rstn = r;
        bus.S_AXIS_tvalid = v;
        bus.S_AXIS_tdata  = d;
        bus.M_AXIS_tready = rdy;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("tvalid",  {31'b0, bus.M_AXIS_tvalid}, {31'b0, m_valid});
        chk("tdata",   bus.M_AXIS_tdata, m_data);
        chk("overrun", {31'b0, ovr}, {31'b0, m_ovr});
    endtask

    task automatic smp(input logic [W-1:0] d, input logic rdy);
        step(1'b1, 1'b1, d, rdy);
    endtask

    initial begin
        bus.S_AXIS_tvalid = 1'b0;
        bus.S_AXIS_tdata  = '0;
        bus.M_AXIS_tready = 1'b1;
        m_have_ref = 0; m_seen = 0; m_l = 0; m_ref = '0;
        m_valid = 0; m_data = '0; m_ovr = 0;

        // Reset state
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b1, 32'd55, 1'b0);
        chk("reset_tvalid", {31'b0, bus.M_AXIS_tvalid}, 32'd0);
        chk("reset_ovr",    {31'b0, ovr}, 32'd0);

        // L=2: samples 0..8 give deltas 4 and 4
        fc = 5'd2;
        for (int i = 0; i <= 8; i++) smp(i, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);

        // L=0 back-to-back deltas
        step(1'b0, 1'b0, '0, 1'b1);
        fc = 5'd0;
        smp(32'd10, 1'b1); smp(32'd7, 1'b1); smp(32'd7, 1'b1); smp(-32'sd3, 1'b1);
        chk("l0_last", bus.M_AXIS_tdata, 32'hFFFF_FFF6);

        // Wrap-around deltas
        step(1'b0, 1'b0, '0, 1'b1);
        smp(32'h7FFF_FFFE, 1'b1); smp(32'h8000_0002, 1'b1);
        chk("wrap_pos", bus.M_AXIS_tdata, 32'd4);
        step(1'b0, 1'b0, '0, 1'b1);
        smp(32'd5, 1'b1); smp(-32'sd5, 1'b1);
        chk("wrap_neg", bus.M_AXIS_tdata, 32'hFFFF_FFF6);

        // Back-pressure and overrun
        step(1'b0, 1'b0, '0, 1'b1);
        smp(32'd0, 1'b0); smp(32'd2, 1'b0); smp(32'd5, 1'b0);
        chk("bp_hold", bus.M_AXIS_tdata, 32'd2);
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        smp(32'd9, 1'b1);
        chk("bp_next", bus.M_AXIS_tdata, 32'd4);

        // Mid-window exponent change
        step(1'b0, 1'b0, '0, 1'b1);
        fc = 5'd2;
        smp(32'd100, 1'b1); smp(32'd101, 1'b1); smp(32'd103, 1'b1);
        fc = 5'd1;
        smp(32'd106, 1'b1); smp(32'd110, 1'b1);
        smp(32'd115, 1'b1); smp(32'd121, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);

        // Reset with a pending output
        fc = 5'd0;
        step(1'b0, 1'b0, '0, 1'b0);
        smp(32'd1, 1'b0); smp(32'd8, 1'b0); smp(32'd20, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        fc = 5'd1;
        smp(32'd3, 1'b1); smp(32'd4, 1'b1); smp(32'd9, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) fc = 5'($urandom_range(0, 3));
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 9) < 7),
                 (($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000),
                 ($urandom_range(0, 9) < 6));
        end

        // Clamped exponent: 17 behaves as 16
        step(1'b0, 1'b0, '0, 1'b1);
        fc = 5'd17;
        for (int i = 0; i <= 65536; i++) begin
            smp(32'(i * 3) + 32'd7, 1'b1);
            if (i == 0) fc = 5'd0;
        end
        step(1'b1, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
